// File: rtl/fifo_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_pkg
// Shared UART constants: FSM state encodings and the bit-period computation.
// The matching receiver imports the same package, so both ends always agree on
// state codes and on how a baud period is derived from the clock.
// -----------------------------------------------------------------------------
package fifo_uart_tx_pkg;

  // FSM state encodings (plain constants so legacy code can reuse them)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int unsigned calc_bit_cycles(input int unsigned clock_freq,
                                                  input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// -----------------------------------------------------------------------------
// baud_tick_counter
// Free-running bit-period counter. Counts 0..BIT_CYCLES-1 and wraps; tick is
// high during the last cycle of each period. clear restarts the period so the
// following cycle sees count 0.
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clear in  restart the bit period (count <= 0 next cycle)
//   tick  out high for one cycle every BIT_CYCLES cycles
// -----------------------------------------------------------------------------
module baud_tick_counter #(
  parameter int unsigned BIT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// UART transmitter that drains an upstream FIFO. In IDLE it pops one word when
// the FIFO is non-empty, captures it during FETCH (FIFO read latency of one
// cycle), then sends start bit, DATA_WIDTH data bits LSB first, and one stop
// bit, each BIT_CYCLES clock cycles long.
//
// Ports:
//   clk         in  system clock, posedge
//   rst         in  synchronous active-high reset (aborts any frame)
//   fifo_empty  in  upstream FIFO has no data
//   fifo_dout   in  upstream FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out one-cycle pop strobe, only in IDLE with data available
//   serial_out  out registered UART line, idle high
//   busy        out high from FETCH through the last stop-bit cycle
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  serial_out,
  output logic                  busy
);

  localparam int unsigned BIT_CYCLES = calc_bit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned BIT_CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  // A bit period shorter than two clocks cannot be timed by the counter.
  generate
    if (BIT_CYCLES < 2) begin : g_bit_cycles_check
      $error("fifo_uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  logic [2:0]            state;
  logic [2:0]            state_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt_next;
  logic                  serial_next;
  logic                  tick;
  logic                  clear;

  // Restarting the bit period on every state change makes each state begin
  // with count 0; inside DATA the natural wrap separates consecutive bits.
  assign clear = (state_next != state);

  baud_tick_counter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        shift_next   = fifo_dout;
        bit_cnt_next = '0;
        state_next   = ST_START;
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = shift >> 1;
          if (bit_cnt == LAST_BIT) begin
            state_next = ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line level for the next cycle, derived from where the FSM is heading so
  // the registered serial_out lines up exactly with the state register.
  always_comb begin
    case (state_next)
      ST_START: serial_next = 1'b0;
      ST_DATA:  serial_next = shift_next[0];
      default:  serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      serial_out <= serial_next;
    end
  end

  // Pop only from IDLE, and never while reset is held; a word popped before a
  // mid-frame reset is simply dropped.
  assign fifo_rd_en = (state == ST_IDLE) && !fifo_empty && !rst;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx with CLOCK_FREQ=1000, BAUD_RATE=100
// (10 clocks per bit). A queue-based FIFO model (depth 32, one-cycle read
// latency) feeds the DUT; an independent line decoder rebuilds frames from
// serial_out and checks every bit cell is stable for exactly 10 cycles.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int BITC  = 10;
  localparam int DEPTH = 32;
  localparam int FRAME = 10 * BITC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       serial_out;
  logic       busy;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .serial_out(serial_out),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] q[$];
  logic       hold = 1'b0;
  logic       push_req = 1'b0;
  logic [7:0] push_data = 8'h00;

  always @(posedge clk) begin
    if (fifo_rd_en && q.size() > 0) fifo_dout <= q.pop_front();
    if (push_req && q.size() < DEPTH) q.push_back(push_data);
    fifo_empty <= hold || (q.size() == 0);
  end

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk); #1;
    push_req  = 1'b1;
    push_data = b;
    @(posedge clk); #1;
    push_req  = 1'b0;
  endtask

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_total = 0, busy_total = 0, viol = 0, rd_cyc = 0;
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_total++;
      rd_cyc = cyc;
      if (fifo_empty || busy || rst) viol++;
    end
    if (busy) busy_total++;
  end

  // Line decoder: frames stored with their start cycle and the count of high
  // samples on the line immediately before the start bit.
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         gap_q[$];
  int         frame_err = 0;

  initial begin : decoder
    int         idle_high, bad, b, st;
    bit         aborted;
    logic [7:0] data;
    idle_high = 0;
    forever begin
      @(negedge clk);
      if (rst) idle_high = 0;
      else if (serial_out === 1'b1) idle_high++;
      else if (serial_out === 1'b0) begin
        st = cyc; aborted = 1'b0; bad = 0; data = 8'h00;
        for (int s = 1; s < FRAME; s++) begin
          @(negedge clk);
          if (rst) begin aborted = 1'b1; break; end
          if (s < BITC) begin
            if (serial_out !== 1'b0) bad++;
          end else if (s < 9 * BITC) begin
            b = s / BITC - 1;
            if (s % BITC == 0) data[b] = serial_out;
            else if (serial_out !== data[b]) bad++;
          end else if (serial_out !== 1'b1) bad++;
        end
        if (aborted) idle_high = 0;
        else begin
          frame_err += bad;
          rx_q.push_back(data);
          start_q.push_back(st);
          gap_q.push_back(idle_high);
          idle_high = BITC;
        end
      end
    end
  end

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return {24'd0, rx_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] gap_at(input int i);
    if (i < gap_q.size()) return gap_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] start_at(input int i);
    if (i < start_q.size()) return start_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic wait_frames(input int n, input int budget, input string tag);
    int i = 0;
    while (rx_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, rx_q.size(), n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd_base, busy_base, rx_base, err;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_serial_out", serial_out, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle: empty FIFO for 200 cycles
    err = 0;
    repeat (200) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) err++;
    end
    check("idle_200_cycles", err, 0);

    // Single byte 0xA5
    @(posedge clk); #1;
    rd_base = rd_total; busy_base = busy_total; rx_base = rx_q.size();
    push_byte(8'hA5);
    wait_frames(rx_base + 1, 300, "a5_frame_seen");
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("a5_data", rx_at(rx_base), 32'hA5);
    check("a5_rd_pulses", rd_total - rd_base, 1);
    check("a5_busy_cycles", busy_total - busy_base, 1 + FRAME);
    check("a5_rd_to_start", start_at(rx_base) - rd_cyc, 2);
    check("a5_line_idle_after", serial_out, 1);

    // Reset mid-frame of 0x3C, then 0x5A goes out intact
    rd_base = rd_total; rx_base = rx_q.size();
    push_byte(8'h3C);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_total > rd_base) break;
    end
    check("rst3c_first_pop", rd_total - rd_base, 1);
    push_byte(8'h5A);
    for (int i = 0; i < 100 && cyc != rd_cyc + 45; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst3c_line_high", serial_out, 1);
    check("rst3c_busy_low", busy, 0);
    @(negedge clk);
    check("rst3c_rd_en_in_rst", fifo_rd_en, 0);
    check("rst3c_still_busy_low", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_frames(rx_base + 1, 300, "rst3c_next_frame_seen");
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("rst3c_next_data", rx_at(rx_base), 32'h5A);
    check("rst3c_rd_pulses", rd_total - rd_base, 2);

    // Back-to-back 0x00, 0xFF
    rd_base = rd_total; rx_base = rx_q.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(rx_base + 2, 500, "b2b_frames_seen");
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("b2b_data0", rx_at(rx_base), 32'h00);
    check("b2b_data1", rx_at(rx_base + 1), 32'hFF);
    check("b2b_rd_pulses", rd_total - rd_base, 2);
    check("b2b_high_gap", gap_at(rx_base + 1), BITC + 2);

    // Fill 32 bytes, then stream
    rd_base = rd_total; rx_base = rx_q.size();
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    @(posedge clk); #1;
    check("fill_no_pop_while_held", rd_total - rd_base, 0);
    hold = 1'b0;
    wait_frames(rx_base + DEPTH, DEPTH * (FRAME + 4) + 200, "stream_frames_seen");
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("stream_rd_pulses", rd_total - rd_base, DEPTH);
    err = 0;
    for (int i = 0; i < DEPTH; i++) if (rx_at(rx_base + i) !== 32'(i)) err++;
    check("stream_order", err, 0);
    err = 0;
    for (int i = 1; i < DEPTH; i++) if (gap_at(rx_base + i) !== 32'(BITC + 2)) err++;
    check("stream_gaps", err, 0);

    // Global invariants
    check("rd_en_violations", viol, 0);
    check("frame_bit_errors", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
